// File: rtl/function_codes.sv
// RV32I func3 encodings for the memory instructions and the access-width type.
package function_codes;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'b00,
      MEM_HALF = 2'b01,
      MEM_WORD = 2'b10,
      MEM_RSVD = 2'b11
   } mem_width_e;

   // The low two func3 bits carry the access width; bit 2 selects zero-extension.
   function automatic mem_width_e widthOf(input logic [2:0] f3);
      return mem_width_e'(f3[1:0]);
   endfunction

endpackage

// File: rtl/opcodes.sv
// RV32I major opcodes shared by the pipeline stages.
package opcodes;

   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering for stores, alignment/width fault detection,
// and load-data extraction with sign or zero extension.
module load_store_align
   import function_codes::*;
#(
   parameter int XLEN = 32
) (
   input  logic            isStore,
   input  logic [2:0]      func3,
   input  logic [1:0]      offset,
   input  logic [XLEN-1:0] storeData,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      wstrb,
   output logic [XLEN-1:0] wdata,
   output logic            fault,
   output logic [XLEN-1:0] loadData
);

   mem_width_e      width;
   logic [XLEN-1:0] shifted;

   assign width = widthOf(func3);

   // Fault rules: width alignment, the reserved width, 11x on any access, and
   // any zero-extend variant on a store.
   always_comb begin
      fault = 1'b0;
      wstrb = 4'b0000;
      wdata = storeData;
      case (width)
         MEM_BYTE: fault = 1'b0;
         MEM_HALF: fault = offset[0];
         MEM_WORD: fault = |offset;
         MEM_RSVD: fault = 1'b1;
      endcase
      if (func3[2] && func3[1]) fault = 1'b1;
      if (isStore && func3[2]) fault = 1'b1;
      if (isStore && !fault) begin
         case (width)
            MEM_BYTE: begin
               wstrb = 4'b0001 << offset;
               wdata = {(XLEN/8){storeData[7:0]}};
            end
            MEM_HALF: begin
               wstrb = 4'b0011 << offset;
               wdata = {(XLEN/16){storeData[15:0]}};
            end
            MEM_WORD: begin
               wstrb = 4'b1111;
               wdata = storeData;
            end
            MEM_RSVD: begin
               wstrb = 4'b0000;
               wdata = storeData;
            end
         endcase
      end
   end

   always_comb begin
      shifted  = rdata >> {offset, 3'b000};
      loadData = shifted;
      case (func3)
         LB:      loadData = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         LBU:     loadData = {{(XLEN-8){1'b0}}, shifted[7:0]};
         LH:      loadData = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         LHU:     loadData = {{(XLEN-16){1'b0}}, shifted[15:0]};
         LW:      loadData = shifted;
         default: loadData = shifted;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// RV32I memory-access stage: word-aligned load/store over a valid/ready data
// port, with lane steering and load extension; other opcodes pass through.
module memory_stage
   import opcodes::*;
   import function_codes::*;
#(
   parameter int XLEN = 32,
   parameter int ILEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      func3,
   input  logic [XLEN-1:0] valE,
   input  logic [XLEN-1:0] valB,
   input  logic [ILEN-1:0] pc,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic [XLEN-1:0] dmem_addr,
   output logic            dmem_we,
   output logic [3:0]      dmem_wstrb,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] valM,
   output logic [XLEN-1:0] valE_out,
   output logic [ILEN-1:0] pc_out,
   output logic            misaligned
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } mem_state_e;

   mem_state_e      state;
   mem_state_e      nextState;
   logic            isLoad;
   logic            isStore;
   logic            accept;
   logic            isLoadReg;
   logic [2:0]      func3Reg;
   logic [2:0]      alignFunc3;
   logic [1:0]      alignOffset;
   logic [3:0]      alignWstrb;
   logic [XLEN-1:0] alignWdata;
   logic [XLEN-1:0] alignLoadData;
   logic            alignFault;

   assign isLoad  = (opcode == LOAD);
   assign isStore = (opcode == STORE);
   assign accept  = in_valid && (state == IDLE);

   // While idle the aligner sees the incoming instruction; afterwards it sees
   // the latched func3/offset so load extraction lines up with the response.
   assign alignFunc3  = (state == IDLE) ? func3 : func3Reg;
   assign alignOffset = (state == IDLE) ? valE[1:0] : valE_out[1:0];

   load_store_align #(
      .XLEN(XLEN)
   ) u_align (
      .isStore   (isStore),
      .func3     (alignFunc3),
      .offset    (alignOffset),
      .storeData (valB),
      .rdata     (dmem_rdata),
      .wstrb     (alignWstrb),
      .wdata     (alignWdata),
      .fault     (alignFault),
      .loadData  (alignLoadData)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Faulted or non-memory instructions skip the memory port and go straight to DONE.
   always_comb begin
      nextState      = state;
      in_ready       = 1'b0;
      dmem_req_valid = 1'b0;
      out_valid      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               nextState = ((isLoad || isStore) && !alignFault) ? REQ : DONE;
            end
         end
         REQ: begin
            dmem_req_valid = 1'b1;
            if (dmem_req_ready) nextState = WAIT;
         end
         WAIT: begin
            if (dmem_rsp_valid) nextState = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) nextState = IDLE;
         end
      endcase
   end

   // valM defaults to valE at acceptance and is overwritten only by load data.
   always_ff @(posedge clk) begin
      if (rst) begin
         valM       <= '0;
         valE_out   <= '0;
         pc_out     <= '0;
         misaligned <= 1'b0;
         dmem_addr  <= '0;
         dmem_we    <= 1'b0;
         dmem_wstrb <= 4'b0000;
         dmem_wdata <= '0;
         func3Reg   <= 3'b000;
         isLoadReg  <= 1'b0;
      end else begin
         if (accept) begin
            valM       <= valE;
            valE_out   <= valE;
            pc_out     <= pc;
            misaligned <= isLoad && alignFault;
            dmem_addr  <= {valE[XLEN-1:2], 2'b00};
            dmem_we    <= isStore && !alignFault;
            dmem_wstrb <= alignWstrb;
            dmem_wdata <= alignWdata;
            func3Reg   <= func3;
            isLoadReg  <= isLoad;
         end
         if ((state == WAIT) && dmem_rsp_valid && isLoadReg) begin
            valM <= alignLoadData;
         end
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Directed scoreboard bench for memory_stage: a background memory responder
// checks requests, the main sequence checks results and handshake timing.
module tb_memory_stage;
   import opcodes::*;
   import function_codes::*;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      bit          chkWdata;
   } req_t;

   typedef struct {
      logic [31:0] valM;
      logic        mis;
      logic [31:0] valE;
      logic [31:0] pc;
   } out_t;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic [31:0] valE;
   logic [31:0] valB;
   logic [31:0] pc;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] valM;
   logic [31:0] valE_out;
   logic [31:0] pc_out;
   logic        misaligned;

   int          total = 0;
   int          bad = 0;
   req_t        reqQ[$];
   out_t        outQ[$];
   int          readyDelay = 0;
   int          rspDelay = 0;
   int          readyCnt = 0;
   int          rspCnt = 0;
   bit          rspArmed = 0;
   logic [31:0] memRdata = '0;
   logic [31:0] curAddr = '0;
   logic [3:0]  curWstrb = '0;
   logic [31:0] pcCounter = 32'h0000_1000;

   memory_stage #(
      .XLEN(32),
      .ILEN(32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .opcode         (opcode),
      .func3          (func3),
      .valE           (valE),
      .valB           (valB),
      .pc             (pc),
      .dmem_req_valid (dmem_req_valid),
      .dmem_req_ready (dmem_req_ready),
      .dmem_addr      (dmem_addr),
      .dmem_we        (dmem_we),
      .dmem_wstrb     (dmem_wstrb),
      .dmem_wdata     (dmem_wdata),
      .dmem_rsp_valid (dmem_rsp_valid),
      .dmem_rdata     (dmem_rdata),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .valM           (valM),
      .valE_out       (valE_out),
      .pc_out         (pc_out),
      .misaligned     (misaligned)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Memory model: delays ready, checks each handshake against the scoreboard,
   // then pulses the response after rspDelay cycles. It ignores reset on purpose.
   initial begin
      req_t r;
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = '0;
      forever begin
         @(negedge clk);
         dmem_rsp_valid = 1'b0;
         dmem_req_ready = 1'b0;
         if (rspArmed) begin
            if (rspCnt == 0) begin
               dmem_rsp_valid = 1'b1;
               dmem_rdata     = memRdata;
               rspArmed       = 0;
            end else begin
               rspCnt--;
            end
         end else if (dmem_req_valid === 1'b1) begin
            if (readyCnt < readyDelay) begin
               readyCnt++;
            end else begin
               dmem_req_ready = 1'b1;
               readyCnt = 0;
               rspArmed = 1;
               rspCnt   = rspDelay;
               compare("req_expected", 32'(reqQ.size()), 32'd1);
               if (reqQ.size() > 0) begin
                  r = reqQ.pop_front();
                  compare("req_addr", dmem_addr, r.addr);
                  compare("req_we", 32'(dmem_we), 32'(r.we));
                  compare("req_wstrb", 32'(dmem_wstrb), 32'(r.wstrb));
                  if (r.chkWdata) compare("req_wdata", dmem_wdata, r.wdata);
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] e,
                                input logic [31:0] b, input logic [31:0] rd,
                                input bit expReq, input bit expWe, input logic [3:0] expWstrb,
                                input bit chkWdata, input logic [31:0] expWdata,
                                input bit expOut, input logic [31:0] expValM, input bit expMis);
      req_t r;
      out_t o;
      compare("in_ready_idle", 32'(in_ready), 32'd1);
      pcCounter = pcCounter + 32'd4;
      if (expReq) begin
         r.addr     = {e[31:2], 2'b00};
         r.we       = expWe;
         r.wstrb    = expWstrb;
         r.wdata    = expWdata;
         r.chkWdata = chkWdata;
         reqQ.push_back(r);
      end
      if (expOut) begin
         o.valM = expValM;
         o.mis  = expMis;
         o.valE = e;
         o.pc   = pcCounter;
         outQ.push_back(o);
      end
      curAddr  = {e[31:2], 2'b00};
      curWstrb = expWstrb;
      memRdata = rd;
      opcode   = op;
      func3    = f3;
      valE     = e;
      valB     = b;
      pc       = pcCounter;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic checkOutput(input int expLatency, input int hold);
      out_t o;
      int   waited = 0;
      while (out_valid !== 1'b1 && waited < 40) begin
         compare("busy_in_ready", 32'(in_ready), 32'd0);
         if (dmem_req_valid === 1'b1) begin
            compare("req_addr_stable", dmem_addr, curAddr);
            compare("req_wstrb_stable", 32'(dmem_wstrb), 32'(curWstrb));
         end
         @(negedge clk);
         waited++;
      end
      compare("out_valid_seen", 32'(out_valid), 32'd1);
      if (out_valid === 1'b1 && outQ.size() > 0) begin
         o = outQ.pop_front();
         compare("latency", 32'(waited), 32'(expLatency));
         for (int i = 0; i <= hold; i++) begin
            compare("out_valid_hold", 32'(out_valid), 32'd1);
            compare("in_ready_done", 32'(in_ready), 32'd0);
            compare("valM", valM, o.valM);
            compare("misaligned", 32'(misaligned), 32'(o.mis));
            compare("valE_out", valE_out, o.valE);
            compare("pc_out", pc_out, o.pc);
            if (i < hold) @(negedge clk);
         end
      end
      compare("req_drained", 32'(reqQ.size()), 32'd0);
      out_ready = 1'b1;
      @(negedge clk);
      compare("out_valid_drop", 32'(out_valid), 32'd0);
      compare("in_ready_back", 32'(in_ready), 32'd1);
   endtask

   task automatic checkReset(input string phase);
      compare({phase, "_in_ready"}, 32'(in_ready), 32'd1);
      compare({phase, "_req_valid"}, 32'(dmem_req_valid), 32'd0);
      compare({phase, "_out_valid"}, 32'(out_valid), 32'd0);
      compare({phase, "_misaligned"}, 32'(misaligned), 32'd0);
      compare({phase, "_valM"}, valM, 32'd0);
      compare({phase, "_valE_out"}, valE_out, 32'd0);
      compare({phase, "_pc_out"}, pc_out, 32'd0);
      compare({phase, "_addr"}, dmem_addr, 32'd0);
      compare({phase, "_wdata"}, dmem_wdata, 32'd0);
      compare({phase, "_wstrb"}, 32'(dmem_wstrb), 32'd0);
      compare({phase, "_we"}, 32'(dmem_we), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      opcode    = '0;
      func3     = '0;
      valE      = '0;
      valB      = '0;
      pc        = '0;
      repeat (3) @(negedge clk);
      checkReset("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] stores and loads with immediate memory");
      applyStimulus(STORE, SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 1, 1, 4'b1111, 1, 32'hDEAD_BEEF, 1, 32'h100, 0);
      checkOutput(2, 0);
      applyStimulus(LOAD, LB, 32'h203, 32'h0, 32'h80FF_1234, 1, 0, 4'b0000, 0, 32'h0, 1, 32'hFFFF_FF80, 0);
      checkOutput(2, 0);
      applyStimulus(LOAD, LBU, 32'h203, 32'h0, 32'h80FF_1234, 1, 0, 4'b0000, 0, 32'h0, 1, 32'h0000_0080, 0);
      checkOutput(2, 0);
      applyStimulus(STORE, SH, 32'h102, 32'h0000_ABCD, 32'h0, 1, 1, 4'b1100, 1, 32'hABCD_ABCD, 1, 32'h102, 0);
      checkOutput(2, 0);
      applyStimulus(LOAD, LH, 32'h202, 32'h0, 32'h8001_0000, 1, 0, 4'b0000, 0, 32'h0, 1, 32'hFFFF_8001, 0);
      checkOutput(2, 0);
      applyStimulus(LOAD, LHU, 32'h202, 32'h0, 32'h8001_0000, 1, 0, 4'b0000, 0, 32'h0, 1, 32'h0000_8001, 0);
      checkOutput(2, 0);
      applyStimulus(LOAD, LW, 32'h204, 32'h0, 32'h1234_5678, 1, 0, 4'b0000, 0, 32'h0, 1, 32'h1234_5678, 0);
      checkOutput(2, 0);
      applyStimulus(STORE, SB, 32'h301, 32'h1234_56A5, 32'h0, 1, 1, 4'b0010, 1, 32'hA5A5_A5A5, 1, 32'h301, 0);
      checkOutput(2, 0);

      $display("[TB] faulting accesses and pass-through");
      applyStimulus(LOAD, LH, 32'h101, 32'h0, 32'h0, 0, 0, 4'b0000, 0, 32'h0, 1, 32'h101, 1);
      checkOutput(0, 0);
      applyStimulus(LOAD, LW, 32'h206, 32'h0, 32'h0, 0, 0, 4'b0000, 0, 32'h0, 1, 32'h206, 1);
      checkOutput(0, 0);
      applyStimulus(STORE, SW, 32'h302, 32'h5555_5555, 32'h0, 0, 0, 4'b0000, 0, 32'h0, 1, 32'h302, 0);
      checkOutput(0, 0);
      applyStimulus(STORE, 3'b100, 32'h300, 32'h5555_5555, 32'h0, 0, 0, 4'b0000, 0, 32'h0, 1, 32'h300, 0);
      checkOutput(0, 0);
      applyStimulus(LOAD, 3'b011, 32'h300, 32'h0, 32'h0, 0, 0, 4'b0000, 0, 32'h0, 1, 32'h300, 1);
      checkOutput(0, 0);
      applyStimulus(LOAD, 3'b110, 32'h300, 32'h0, 32'h0, 0, 0, 4'b0000, 0, 32'h0, 1, 32'h300, 1);
      checkOutput(0, 0);
      applyStimulus(OP, 3'b000, 32'h1234, 32'h9999, 32'h0, 0, 0, 4'b0000, 0, 32'h0, 1, 32'h1234, 0);
      checkOutput(0, 0);

      $display("[TB] back-pressure on request, response and output");
      readyDelay = 3;
      rspDelay   = 2;
      out_ready  = 1'b0;
      applyStimulus(LOAD, LW, 32'h208, 32'h0, 32'hCAFE_F00D, 1, 0, 4'b0000, 0, 32'h0, 1, 32'hCAFE_F00D, 0);
      checkOutput(7, 2);
      readyDelay = 0;
      rspDelay   = 0;

      $display("[TB] reset while waiting for a response");
      rspDelay = 3;
      applyStimulus(LOAD, LW, 32'h40, 32'h0, 32'h1111_2222, 1, 0, 4'b0000, 0, 32'h0, 0, 32'h0, 0);
      @(negedge clk);
      compare("wait_in_ready", 32'(in_ready), 32'd0);
      compare("wait_req_valid", 32'(dmem_req_valid), 32'd0);
      compare("wait_out_valid", 32'(out_valid), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkReset("midreset");
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         compare("late_rsp_out_valid", 32'(out_valid), 32'd0);
         compare("late_rsp_in_ready", 32'(in_ready), 32'd1);
      end
      rspDelay = 0;
      applyStimulus(LOAD, LBU, 32'h41, 32'h0, 32'h0000_7F00, 1, 0, 4'b0000, 0, 32'h0, 1, 32'h0000_007F, 0);
      checkOutput(2, 0);

      compare("out_queue_empty", 32'(outQ.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory-access stage of the RV32I pipeline. It sits directly after the execute stage and consumes its result (valE as effective address, valB as store data).
- Issues word-aligned load/store transactions to a data-memory port using a valid/ready handshake.
- Performs byte-lane steering, sign/zero extension and alignment checking, then hands valM downstream.
- Non-memory opcodes pass through untouched.

Parameters:
- XLEN, 32, data/address width.
- ILEN, 32, instruction/pc width (pc forwarded unchanged).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream holds valid opcode/func3/valE/valB/pc
- in_ready  output  1  stage can accept a new instruction
- opcode  input  7  instruction opcode
- func3  input  3  width/sign selector
- valE  input  XLEN  execute result / effective address
- valB  input  XLEN  store data (rs2)
- pc  input  ILEN  instruction pc
- dmem_req_valid  output  1  memory request valid
- dmem_req_ready  input  1  memory accepts request
- dmem_addr  output  XLEN  word-aligned address ({valE[XLEN-1:2],2'b00})
- dmem_we  output  1  1 = store
- dmem_wstrb  output  4  byte enables
- dmem_wdata  output  XLEN  lane-shifted store data
- dmem_rsp_valid  input  1  read data / write ack valid (one-cycle pulse)
- dmem_rdata  input  XLEN  read word
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- valM  output  XLEN  load result, or valE for non-loads
- valE_out  output  XLEN  registered valE
- pc_out  output  ILEN  registered pc
- misaligned  output  1  alignment/illegal-width fault, qualified by out_valid

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - state = IDLE; in_ready = 1.
  - dmem_req_valid = 0, out_valid = 0, misaligned = 0.
  - valM, valE_out, pc_out, dmem_addr, dmem_wdata = 0; dmem_wstrb = 0; dmem_we = 0.
- Reset mid-transaction: returns to IDLE immediately and drops dmem_req_valid. A dmem_rsp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE. in_ready = (state == IDLE).
- IDLE, on in_valid:
  - Latch all inputs.
  - opcode LOAD(0000011) or STORE(0100011) with valid alignment -> REQ.
  - All other opcodes, or a fault -> DONE with valM = valE.
  - Only LOAD faults assert misaligned.
- Alignment rules:
  - Byte (func3[1:0] = 00): any address.
  - Half (01): addr[0] = 0.
  - Word (10): addr[1:0] = 00.
  - func3 of 011, 110, 111 on LOAD/STORE is a fault. So are 011 and 1xx on STORE.
  - A faulted access issues no dmem request; misaligned = 1 in DONE.
- REQ: dmem_req_valid = 1; address, we, wstrb, wdata held stable until dmem_req_ready. Handshake cycle -> WAIT.
- WAIT: wait for dmem_rsp_valid (any number of cycles) -> DONE.
  - Loads register valM on that cycle.
  - Stores ignore rdata.
- DONE: out_valid = 1; outputs held stable until out_ready, then -> IDLE. Same-cycle re-accept is not allowed.
- Latency (zero-wait memory, out_ready = 1): load/store 4 cycles from acceptance to out_valid deassert; non-memory ops 2 cycles.
- Store steering, with o = addr[1:0]:
  - SB: wstrb = 0001 << o; wdata = {4{valB[7:0]}}.
  - SH: wstrb = 0011 << o; wdata = {2{valB[15:0]}}.
  - SW: wstrb = 1111; wdata = valB.
- Load extraction: byte = rdata >> (8*o), then:
  - LB: sign-extend [7:0]; LBU: zero-extend [7:0].
  - LH: sign-extend [15:0]; LHU: zero-extend [15:0].
  - LW: full word.
- dmem_wstrb = 0 and dmem_we = 0 for loads.

Decomposition:
- Extend package `opcodes` (LOAD, STORE already present).
- Extend package `function_codes` with LB, LH, LW, LBU, LHU, SB, SH, SW and a `mem_width_e` enum.
- FSM state enum `mem_state_e` is local to the module.
- One combinational sub-module, `load_store_align`: generates wstrb/wdata/fault from func3 and addr, and extracts/extends load data from rdata.

Test Plan:
- SW valE = 0x100, valB = 0xDEADBEEF, ready/rsp immediate -> dmem_addr = 0x100, wstrb = 1111, wdata = 0xDEADBEEF, we = 1; out_valid with misaligned = 0.
- LB valE = 0x203, rdata = 0x80FF_1234 -> wstrb = 0; valM = 0xFFFFFF80. LBU same stimulus -> valM = 0x00000080.
- SH valE = 0x102, valB = 0x0000ABCD -> wstrb = 1100, wdata = 0xABCDABCD. LH valE = 0x101 -> no dmem_req_valid, out_valid with misaligned = 1.
- Back-pressure: dmem_req_ready low 3 cycles, dmem_rsp_valid 2 cycles later, out_ready low 2 cycles -> addr/wstrb/valM stable throughout; in_ready = 0 until the out handshake completes.
- OP instruction valE = 0x1234 -> no dmem request; out_valid two cycles after accept; valM = 0x1234.
- rst asserted in WAIT -> next cycle IDLE, in_ready = 1, outputs zero; a late dmem_rsp_valid produces no out_valid.
